inv_mix_columns_iter: RTL and testbench

Iterative AES InvMixColumns engine for the decryption datapath. It is the inverse of the existing combinational MixColumns stage. It accepts one 128-bit state through a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock. It then holds the result until the downstream stage accepts it. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the iterative decryption round loop, trading area for latency.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/inv_mix_columns_iter_column.sv | 14 +
 rtl/inv_mix_columns_iter.sv | 60 ++++++
 tb/tb_inv_mix_columns_iter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES GF(2^8) helpers, state/column types and the InvMixColumns engine state enum.
package aes_pkg;
  localparam logic [7:0] AES_POLY = 8'h1B;
  typedef logic [127:0] aes_state_t;
  typedef logic [31:0] aes_col_t;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} imc_state_t;
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul09(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = gf_xtime(b);
    x8 = gf_xtime(gf_xtime(x2));
    return x8 ^ b;
  endfunction
  function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = gf_xtime(b);
    x8 = gf_xtime(gf_xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction
  function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = gf_xtime(gf_xtime(b));
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction
  function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction
endpackage

// File: rtl/inv_mix_columns_iter_column.sv
// inv_mix_single_column: combinational InvMixColumns transform of one 32-bit column.
module inv_mix_single_column
  import aes_pkg::*;
(
  input  aes_col_t col_in,
  output aes_col_t col_out
);
  logic [7:0] s0, s1, s2, s3;
  assign {s0, s1, s2, s3} = col_in;
  assign col_out = {gf_mul0e(s0) ^ gf_mul0b(s1) ^ gf_mul0d(s2) ^ gf_mul09(s3),
                    gf_mul09(s0) ^ gf_mul0e(s1) ^ gf_mul0b(s2) ^ gf_mul0d(s3),
                    gf_mul0d(s0) ^ gf_mul09(s1) ^ gf_mul0e(s2) ^ gf_mul0b(s3),
                    gf_mul0b(s0) ^ gf_mul0d(s1) ^ gf_mul09(s2) ^ gf_mul0e(s3)};
endmodule

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative InvMixColumns, COLS_PER_CYCLE columns per clock,
// valid/ready in and out, result held in res_reg until accepted.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t data_in,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t data_out,
  output logic       busy
);
  localparam int NCYC = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(NCYC - 1);
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  imc_state_t state, state_nxt;
  logic [1:0] col_cnt;
  logic [0:3][31:0] src_reg, res_reg;
  logic [1:0] idx [COLS_PER_CYCLE];
  aes_col_t col_res [COLS_PER_CYCLE];
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign idx[g] = 2'(int'(col_cnt) * COLS_PER_CYCLE + g);
    inv_mix_single_column u_col (
      .col_in (src_reg[idx[g]]),
      .col_out(col_res[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE    ? (in_valid ? COMPUTE : IDLE) :
                state == COMPUTE ? (col_cnt == LAST ? DONE : COMPUTE) :
                state == DONE    ? (out_ready ? IDLE : DONE) : IDLE;
  always_comb begin
    in_ready  = state == IDLE;
    busy      = state == COMPUTE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_cnt <= '0;
      src_reg <= '0;
      res_reg <= '0;
    end else if (state == IDLE && in_valid) begin
      col_cnt <= '0;
      src_reg <= data_in;
    end else if (state == COMPUTE) begin
      col_cnt <= col_cnt == LAST ? 2'd0 : col_cnt + 2'd1;
      for (int i = 0; i < COLS_PER_CYCLE; i++) res_reg[idx[i]] <= col_res[i];
    end
  assign data_out = res_reg;
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb_inv_mix_columns_iter: randomized and directed checks of the InvMixColumns engine
// against a matrix-level GF(2^8) model, for COLS_PER_CYCLE = 1, 2, 4.
module tb_inv_mix_columns_iter;
  logic clk = 0, rst_n = 0, iv1 = 0, v2 = 0, v4 = 0, out_ready = 0;
  logic [127:0] data_in = '0;
  logic ir1, ir2, ir4, ov1, ov2, ov4, b1, b2, b4;
  logic [127:0] do1, do2, do4;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .data_in(data_in), .out_valid(ov1), .out_ready(out_ready), .data_out(do1), .busy(b1));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2),
    .data_in(data_in), .out_valid(ov2), .out_ready(out_ready), .data_out(do2), .busy(b2));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4),
    .data_in(data_in), .out_valid(ov4), .out_ready(out_ready), .data_out(do4), .busy(b4));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product: row r, input byte k uses coefficient m[(k-r) mod 4]
  function automatic logic [127:0] mix(input logic [127:0] x, input logic [31:0] m);
    logic [127:0] y = '0;
    logic [7:0] cf [4];
    for (int k = 0; k < 4; k++) cf[k] = m[31-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        logic [7:0] t = 0;
        for (int k = 0; k < 4; k++) t ^= gmul(cf[(k - r + 4) % 4], x[127-32*c-8*k -: 8]);
        y[127-32*c-8*r -: 8] = t;
      end
    return y;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] x);
    return mix(x, 32'h0e0b0d09);
  endfunction
  function automatic logic [127:0] fwd_mix(input logic [127:0] x);
    return mix(x, 32'h02030101);
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 0;
    #3;
    total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", ir1); end
    total++; if ({ov1, ov2, ov4} !== 3'b000) begin bad++; $display("FAIL reset_out_valid got %b want 000", {ov1, ov2, ov4}); end
    total++; if ({b1, b2, b4} !== 3'b000) begin bad++; $display("FAIL reset_busy got %b want 000", {b1, b2, b4}); end
    total++; if (do1 !== 128'h0) begin bad++; $display("FAIL reset_data_out got %h want 0", do1); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_single();
    logic [127:0] exp = 128'hdb135345_f20a225c_01010101_2d26314c;
    int n = 0, bc = 0;
    data_in = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    total++; if (inv_mix(data_in) !== exp) begin bad++; $display("FAIL model_vector got %h want %h", inv_mix(data_in), exp); end
    iv1 = 1;
    @(posedge clk); #1 iv1 = 0;
    while (!ov1 && n < 20) begin
      n++; bc += int'(b1);
      @(posedge clk); #1;
    end
    n++;
    total++; if (n !== 5) begin bad++; $display("FAIL single_latency got %0d want 5", n); end
    total++; if (bc !== 4) begin bad++; $display("FAIL single_busy_cycles got %0d want 4", bc); end
    total++; if (do1 !== exp) begin bad++; $display("FAIL single_data got %h want %h", do1, exp); end
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    total++; if (ov1 !== 1'b0 || ir1 !== 1'b1) begin bad++; $display("FAIL single_release got ov=%b ir=%b want 0 1", ov1, ir1); end
  endtask

  task automatic test_fixed();
    logic [127:0] exp = 128'hc6c6c6c6_01010101_d4d4d4d5_00000000;
    int n1 = -1, n2 = -1, n4 = -1;
    data_in = 128'hc6c6c6c6_01010101_d5d5d7d6_00000000;
    {iv1, v2, v4} = 3'b111;
    @(posedge clk); #1 {iv1, v2, v4} = 3'b000;
    for (int n = 1; n < 10; n++) begin
      if (ov1 && n1 < 0) n1 = n;
      if (ov2 && n2 < 0) n2 = n;
      if (ov4 && n4 < 0) n4 = n;
      @(posedge clk); #1;
    end
    total++; if (n1 !== 5) begin bad++; $display("FAIL fixed_lat1 got %0d want 5", n1); end
    total++; if (n2 !== 3) begin bad++; $display("FAIL fixed_lat2 got %0d want 3", n2); end
    total++; if (n4 !== 2) begin bad++; $display("FAIL fixed_lat4 got %0d want 2", n4); end
    total++; if (do1 !== exp || do1 !== inv_mix(data_in)) begin bad++; $display("FAIL fixed_data1 got %h want %h", do1, exp); end
    total++; if (do2 !== exp) begin bad++; $display("FAIL fixed_data2 got %h want %h", do2, exp); end
    total++; if (do4 !== exp) begin bad++; $display("FAIL fixed_data4 got %h want %h", do4, exp); end
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    total++; if ({ov1, ov2, ov4} !== 3'b000) begin bad++; $display("FAIL fixed_release got %b want 000", {ov1, ov2, ov4}); end
  endtask

  task automatic test_backpressure();
    logic [127:0] x = rnd128();
    int n = 0;
    data_in = fwd_mix(x);
    iv1 = 1;
    @(posedge clk); #1 iv1 = 0;
    while (!ov1 && n < 20) begin @(posedge clk); #1 n++; end
    total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL bp_timeout got out_valid %b want 1", ov1); end
    iv1 = 1;
    data_in = rnd128();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (ov1 !== 1'b1 || do1 !== x || ir1 !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc %0d got ov=%b ir=%b data=%h want 1 0 %h", i, ov1, ir1, do1, x);
      end
    end
    iv1 = 0; out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    total++; if (ov1 !== 1'b0 || ir1 !== 1'b1) begin bad++; $display("FAIL bp_release got ov=%b ir=%b want 0 1", ov1, ir1); end
    @(posedge clk); #1;
    total++; if (b1 !== 1'b0 || do1 !== x) begin bad++; $display("FAIL bp_no_latch got busy=%b data=%h want 0 %h", b1, do1, x); end
  endtask

  task automatic test_reset_mid();
    data_in = rnd128();
    iv1 = 1;
    @(posedge clk); #1 iv1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    #1;
    total++; if (ir1 !== 1'b1 || ov1 !== 1'b0 || b1 !== 1'b0 || do1 !== 128'h0) begin
      bad++; $display("FAIL mid_reset got ir=%b ov=%b busy=%b data=%h want 1 0 0 0", ir1, ov1, b1, do1);
    end
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (ov1 !== 1'b0 || b1 !== 1'b0) begin bad++; $display("FAIL mid_reset_after cyc %0d got ov=%b busy=%b want 0 0", i, ov1, b1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] q[$];
    logic [127:0] x, got;
    int nacc = 0, nout = 0, cyc = 0, last = -1;
    logic acc, take;
    x = rnd128();
    data_in = fwd_mix(x);
    iv1 = 1; out_ready = 1;
    while (nout < 100 && cyc < 2000) begin
      acc = iv1 && ir1; take = ov1 && out_ready; got = do1;
      @(posedge clk); #1 cyc++;
      if (take) begin
        total++;
        if (q.size() == 0 || got !== q[0]) begin bad++; $display("FAIL b2b_data #%0d got %h want %h", nout, got, q.size() ? q[0] : 128'hx); end
        if (q.size() != 0) void'(q.pop_front());
        nout++;
      end
      if (acc) begin
        if (last >= 0) begin
          total++; if (cyc - last != 6) begin bad++; $display("FAIL b2b_spacing got %0d want 6", cyc - last); end
        end
        last = cyc;
        q.push_back(x);
        nacc++;
        if (nacc < 100) begin x = rnd128(); data_in = fwd_mix(x); end
        else iv1 = 0;
      end
    end
    iv1 = 0; out_ready = 0;
    total++; if (nout != 100) begin bad++; $display("FAIL b2b_count got %0d want 100", nout); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
